// File: rtl/cpu_pkg.sv
// Shared ISA definitions for the parametrised accumulator CPU:
// opcode values, FSM state encoding and opcode-class predicates.
package cpu_pkg;

  localparam int unsigned OPC_W = 5;

  localparam logic [OPC_W-1:0] OP_HLT  = 5'h00;
  localparam logic [OPC_W-1:0] OP_STO  = 5'h01;
  localparam logic [OPC_W-1:0] OP_LD   = 5'h02;
  localparam logic [OPC_W-1:0] OP_LDI  = 5'h03;
  localparam logic [OPC_W-1:0] OP_ADD  = 5'h04;
  localparam logic [OPC_W-1:0] OP_ADDI = 5'h05;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'h06;
  localparam logic [OPC_W-1:0] OP_SUBI = 5'h07;
  localparam logic [OPC_W-1:0] OP_AND  = 5'h08;
  localparam logic [OPC_W-1:0] OP_ANDI = 5'h09;
  localparam logic [OPC_W-1:0] OP_OR   = 5'h0A;
  localparam logic [OPC_W-1:0] OP_ORI  = 5'h0B;
  localparam logic [OPC_W-1:0] OP_XOR  = 5'h0C;
  localparam logic [OPC_W-1:0] OP_XORI = 5'h0D;
  localparam logic [OPC_W-1:0] OP_JMP  = 5'h0E;
  localparam logic [OPC_W-1:0] OP_BEQ  = 5'h0F;
  localparam logic [OPC_W-1:0] OP_BNE  = 5'h10;
  localparam logic [OPC_W-1:0] OP_BN   = 5'h11;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  // Instructions that read data memory (loads and ALU-with-memory ops)
  function automatic logic is_mem_rd(input logic [OPC_W-1:0] op);
    case (op)
      OP_LD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: return 1'b1;
      default:                                      return 1'b0;
    endcase
  endfunction

  function automatic logic is_mem_wr(input logic [OPC_W-1:0] op);
    return (op == OP_STO);
  endfunction

  function automatic logic is_imm(input logic [OPC_W-1:0] op);
    case (op)
      OP_LDI, OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_XORI: return 1'b1;
      default:                                            return 1'b0;
    endcase
  endfunction

  // Conditional branches only; JMP is unconditional and handled separately
  function automatic logic is_branch(input logic [OPC_W-1:0] op);
    case (op)
      OP_BEQ, OP_BNE, OP_BN: return 1'b1;
      default:               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational next-accumulator function; memory and immediate forms share
// one datapath since the operand value is already resolved by the caller.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic [OPC_W-1:0]  opcode,
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] operand,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = acc;
    case (opcode)
      OP_LD,  OP_LDI:  result = operand;
      OP_ADD, OP_ADDI: result = acc + operand;
      OP_SUB, OP_SUBI: result = acc - operand;
      OP_AND, OP_ANDI: result = acc & operand;
      OP_OR,  OP_ORI:  result = acc | operand;
      OP_XOR, OP_XORI: result = acc ^ operand;
      default:         result = acc;
    endcase
  end

endmodule

// File: rtl/cpu_param.sv
// Parametrised accumulator CPU: RUN/WAIT/HALT sequencer, PC, ACC and the
// ready-handshake data-memory interface between program ROM and data RAM.
module cpu_param
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 11
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic [ADDR_W-1:0]       addr_program,
  input  logic [OPC_W+ADDR_W-1:0] data,
  output logic                    rd,
  output logic                    wr,
  output logic [ADDR_W-1:0]       addr_data,
  output logic [DATA_W-1:0]       in_data,
  input  logic [DATA_W-1:0]       out_data,
  input  logic                    data_ready,
  output logic [DATA_W-1:0]       acc,
  output logic                    halted
);

  if (DATA_W < ADDR_W) begin : g_width_check
    $error("cpu_param: DATA_W must be >= ADDR_W");
  end

  state_t              state;
  logic [ADDR_W-1:0]   pc;
  logic [OPC_W-1:0]    opcode;
  logic [ADDR_W-1:0]   operand;
  logic [DATA_W-1:0]   opnd_val;
  logic [DATA_W-1:0]   alu_res;
  logic                mem_rd;
  logic                mem_wr;
  logic                in_access;
  logic                taken;
  logic [ADDR_W-1:0]   pc_inc;

  assign opcode  = data[OPC_W+ADDR_W-1 -: OPC_W];
  assign operand = data[ADDR_W-1:0];
  assign mem_rd  = is_mem_rd(opcode);
  assign mem_wr  = is_mem_wr(opcode);
  assign pc_inc  = pc + ADDR_W'(1);

  // Immediates are sign-extended; everything else takes the RAM read data
  assign opnd_val = is_imm(opcode) ? DATA_W'($signed(operand)) : out_data;

  always_comb begin
    taken = 1'b0;
    if (opcode == OP_JMP) begin
      taken = 1'b1;
    end else if (is_branch(opcode)) begin
      case (opcode)
        OP_BEQ:  taken = (acc == '0);
        OP_BNE:  taken = (acc != '0);
        default: taken = acc[DATA_W-1];
      endcase
    end
  end

  cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .opcode  (opcode),
    .acc     (acc),
    .operand (opnd_val),
    .result  (alu_res)
  );

  // Requests follow the instruction word directly; PC and ACC are frozen in
  // WAIT so the request is naturally held. Gated off while reset is asserted.
  assign in_access    = reset && ((state == ST_RUN) || (state == ST_WAIT));
  assign rd           = in_access && mem_rd;
  assign wr           = in_access && mem_wr;
  assign addr_data    = reset ? operand : '0;
  assign in_data      = acc;
  assign addr_program = pc;
  assign halted       = (state == ST_HALT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_RUN;
      pc    <= '0;
      acc   <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (opcode == OP_HLT) begin
            state <= ST_HALT;
          end else if (mem_rd || mem_wr) begin
            if (data_ready) begin
              acc <= alu_res;
              pc  <= pc_inc;
            end else begin
              state <= ST_WAIT;
            end
          end else begin
            acc <= alu_res;
            pc  <= taken ? operand : pc_inc;
          end
        end
        ST_WAIT: begin
          if (data_ready) begin
            acc   <= alu_res;
            pc    <= pc_inc;
            state <= ST_RUN;
          end
        end
        ST_HALT: begin
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_param.sv
// Self-checking bench for cpu_param: directed sequences, a vector table of
// single-instruction cases, and random programs against an ISA-level model.
module tb_cpu_param;
  import cpu_pkg::*;

  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 11;
  localparam int unsigned DEPTH = 2048;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] addr_program;
  logic [15:0]   data;
  logic          rd, wr;
  logic [AW-1:0] addr_data;
  logic [DW-1:0] in_data;
  logic [DW-1:0] out_data;
  logic          data_ready = 1'b0;
  logic [DW-1:0] acc;
  logic          halted;

  logic [15:0] rom  [DEPTH];
  logic [15:0] ram  [DEPTH];
  logic [15:0] mram [DEPTH];

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [4:0]  op;
    logic [10:0] opnd;
    logic [15:0] acc0;
    logic [15:0] mem;
    logic [15:0] exp_acc;
    logic [10:0] exp_pc;
  } vec_t;

  vec_t vt [15];

  always #5 clk = ~clk;

  assign data     = rom[addr_program];
  assign out_data = ram[addr_data];

  cpu_param #(.DATA_W(16), .ADDR_W(11)) dut (
    .clk          (clk),
    .reset        (reset),
    .addr_program (addr_program),
    .data         (data),
    .rd           (rd),
    .wr           (wr),
    .addr_data    (addr_data),
    .in_data      (in_data),
    .out_data     (out_data),
    .data_ready   (data_ready),
    .acc          (acc),
    .halted       (halted)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ins(input logic [4:0] op, input logic [10:0] k);
    return {op, k};
  endfunction

  function automatic logic [15:0] sext(input logic [10:0] v);
    return {{5{v[10]}}, v};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < DEPTH; i++) begin
      rom[i] = {5'h1F, 11'h000};
      ram[i] = '0;
    end
  endtask

  // Called at negedge+1: RAM accepts a write on the coming edge, then advance
  task automatic tick();
    if (wr && data_ready) ram[addr_data] = in_data;
    @(negedge clk);
  endtask

  task automatic do_reset();
    data_ready = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Random program run checked against an instruction-level model
  task automatic rand_run(input int n, input int run_id);
    logic [4:0]  op;
    logic [10:0] k;
    logic [10:0] m_pc;
    logic [15:0] m_acc;
    logic [15:0] x;
    logic        m_halt, is_rd, is_wr;
    int          d;
    for (int j = 0; j < DEPTH; j++) begin
      op = 5'($urandom_range(0, 31));
      if (op == OP_HLT && $urandom_range(0, 9) != 0) op = OP_LD;
      rom[j]  = {op, 11'($urandom)};
      ram[j]  = 16'($urandom);
      mram[j] = ram[j];
    end
    do_reset();
    m_pc = '0; m_acc = '0; m_halt = 1'b0;
    for (int i = 0; i < n && !m_halt; i++) begin
      op    = rom[m_pc][15:11];
      k     = rom[m_pc][10:0];
      is_rd = op inside {OP_LD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR};
      is_wr = (op == OP_STO);
      d     = (is_rd || is_wr) ? $urandom_range(0, 3) : 0;
      for (int c = 0; c <= d; c++) begin
        data_ready = (is_rd || is_wr) ? (c == d) : 1'($urandom_range(0, 1));
        #1;
        chk($sformatf("rnd%0d_i%0d_pc", run_id, i), addr_program, m_pc);
        chk($sformatf("rnd%0d_i%0d_acc", run_id, i), acc, m_acc);
        chk($sformatf("rnd%0d_i%0d_rd", run_id, i), rd, is_rd);
        chk($sformatf("rnd%0d_i%0d_wr", run_id, i), wr, is_wr);
        chk($sformatf("rnd%0d_i%0d_halted", run_id, i), halted, 0);
        if (is_rd || is_wr) begin
          chk($sformatf("rnd%0d_i%0d_addr", run_id, i), addr_data, k);
          chk($sformatf("rnd%0d_i%0d_wdata", run_id, i), in_data, m_acc);
        end
        tick();
      end
      x = is_rd ? mram[k] : sext(k);
      m_pc = 11'((32'(m_pc) + 1) % DEPTH);
      case (op)
        OP_HLT:           begin m_halt = 1'b1; m_pc = rom[m_pc - 11'd1][10:0] == k ? m_pc - 11'd1 : m_pc - 11'd1; end
        OP_STO:           mram[k] = m_acc;
        OP_LD,  OP_LDI:   m_acc = x;
        OP_ADD, OP_ADDI:  m_acc = 16'((32'(m_acc) + 32'(x)) % 65536);
        OP_SUB, OP_SUBI:  m_acc = 16'((65536 + 32'(m_acc) - 32'(x)) % 65536);
        OP_AND, OP_ANDI:  m_acc = m_acc & x;
        OP_OR,  OP_ORI:   m_acc = m_acc | x;
        OP_XOR, OP_XORI:  m_acc = m_acc ^ x;
        OP_JMP:           m_pc = k;
        OP_BEQ:           if (m_acc == 0) m_pc = k;
        OP_BNE:           if (m_acc != 0) m_pc = k;
        OP_BN:            if (m_acc >= 16'h8000) m_pc = k;
        default:          ;
      endcase
      if (is_wr) chk($sformatf("rnd%0d_i%0d_ram", run_id, i), ram[k], mram[k]);
    end
    if (m_halt) begin
      for (int c = 0; c < 4; c++) begin
        data_ready = 1'($urandom_range(0, 1));
        #1;
        chk($sformatf("rnd%0d_halt%0d_pc", run_id, c), addr_program, m_pc);
        chk($sformatf("rnd%0d_halt%0d_acc", run_id, c), acc, m_acc);
        chk($sformatf("rnd%0d_halt%0d_halted", run_id, c), halted, 1);
        chk($sformatf("rnd%0d_halt%0d_rdwr", run_id, c), {rd, wr}, 0);
        tick();
      end
    end else begin
      #1;
      chk($sformatf("rnd%0d_end_pc", run_id), addr_program, m_pc);
      chk($sformatf("rnd%0d_end_acc", run_id), acc, m_acc);
    end
  endtask

  initial begin
    int exp_pc [6];

    vt[0]  = '{OP_ADD,  11'h100, 16'h1234, 16'h0F0F, 16'h2143, 11'h002};
    vt[1]  = '{OP_SUB,  11'h100, 16'h0001, 16'h0002, 16'hFFFF, 11'h002};
    vt[2]  = '{OP_AND,  11'h100, 16'hF0F0, 16'h3C3C, 16'h3030, 11'h002};
    vt[3]  = '{OP_OR,   11'h100, 16'hF0F0, 16'h0F01, 16'hFFF1, 11'h002};
    vt[4]  = '{OP_XOR,  11'h100, 16'hAAAA, 16'hFFFF, 16'h5555, 11'h002};
    vt[5]  = '{OP_LD,   11'h100, 16'h0000, 16'hBEEF, 16'hBEEF, 11'h002};
    vt[6]  = '{OP_ANDI, 11'h400, 16'h1234, 16'h0000, 16'h1000, 11'h002};
    vt[7]  = '{OP_ORI,  11'h00F, 16'h1200, 16'h0000, 16'h120F, 11'h002};
    vt[8]  = '{OP_XORI, 11'h7FF, 16'h00FF, 16'h0000, 16'hFF00, 11'h002};
    vt[9]  = '{OP_ADDI, 11'h001, 16'hFFFF, 16'h0000, 16'h0000, 11'h002};
    vt[10] = '{OP_BN,   11'h123, 16'h8000, 16'h0000, 16'h8000, 11'h123};
    vt[11] = '{OP_BEQ,  11'h050, 16'h0001, 16'h0000, 16'h0001, 11'h002};
    vt[12] = '{5'h1F,   11'h000, 16'h4321, 16'h0000, 16'h4321, 11'h002};
    vt[13] = '{OP_BNE,  11'h300, 16'h0001, 16'h0000, 16'h0001, 11'h300};
    vt[14] = '{OP_SUBI, 11'h7FF, 16'h0005, 16'h0000, 16'h0006, 11'h002};

    // Reset state, with a load sitting at address 0
    clear_mem();
    rom[0] = ins(OP_LD, 11'h010);
    @(negedge clk);
    data_ready = 1'b1;
    reset = 1'b0;
    #1;
    chk("rst_pc", addr_program, 0);
    chk("rst_acc", acc, 0);
    chk("rst_rd", rd, 0);
    chk("rst_wr", wr, 0);
    chk("rst_halted", halted, 0);
    chk("rst_addr", addr_data, 0);
    chk("rst_wdata", in_data, 0);

    // Immediates then HLT
    clear_mem();
    rom[0] = ins(OP_LDI, 11'h005);
    rom[1] = ins(OP_ADDI, 11'h7FD);
    rom[2] = ins(OP_SUBI, 11'h004);
    rom[3] = ins(OP_HLT, 11'h000);
    do_reset();
    data_ready = 1'b1;
    #1; chk("imm_acc0", acc, 0); tick();
    #1; chk("imm_acc1", acc, 16'h0005); chk("imm_pc1", addr_program, 1); tick();
    #1; chk("imm_acc2", acc, 16'h0002); chk("imm_pc2", addr_program, 2); tick();
    #1; chk("imm_acc3", acc, 16'hFFFE); chk("imm_pc3", addr_program, 3); chk("imm_nohalt", halted, 0); tick();
    for (int c = 0; c < 10; c++) begin
      #1;
      chk($sformatf("halt%0d_pc", c), addr_program, 3);
      chk($sformatf("halt%0d_halted", c), halted, 1);
      chk($sformatf("halt%0d_acc", c), acc, 16'hFFFE);
      chk($sformatf("halt%0d_rdwr", c), {rd, wr}, 0);
      tick();
    end

    // Load with three wait states
    clear_mem();
    ram[16'h10] = 16'h1234;
    rom[0] = ins(OP_LD, 11'h010);
    do_reset();
    for (int c = 0; c <= 3; c++) begin
      data_ready = (c == 3);
      #1;
      chk($sformatf("ldw%0d_rd", c), rd, 1);
      chk($sformatf("ldw%0d_wr", c), wr, 0);
      chk($sformatf("ldw%0d_addr", c), addr_data, 11'h010);
      chk($sformatf("ldw%0d_acc", c), acc, 0);
      chk($sformatf("ldw%0d_pc", c), addr_program, 0);
      tick();
    end
    #1;
    chk("ldw_acc_done", acc, 16'h1234);
    chk("ldw_pc_done", addr_program, 1);

    // Store
    clear_mem();
    rom[0] = ins(OP_LDI, 11'h02A);
    rom[1] = ins(OP_STO, 11'h020);
    do_reset();
    data_ready = 1'b1;
    #1; tick();
    #1;
    chk("sto_wr", wr, 1);
    chk("sto_rd", rd, 0);
    chk("sto_addr", addr_data, 11'h020);
    chk("sto_wdata", in_data, 16'h002A);
    tick();
    #1;
    chk("sto_ram", ram[11'h020], 16'h002A);
    chk("sto_pc", addr_program, 2);
    chk("sto_wr_off", wr, 0);

    // Branches
    clear_mem();
    rom[0]  = ins(OP_LDI, 11'h000);
    rom[1]  = ins(OP_BEQ, 11'h008);
    rom[8]  = ins(OP_BNE, 11'h000);
    rom[9]  = ins(OP_LDI, 11'h7FF);
    rom[10] = ins(OP_BN,  11'h040);
    exp_pc = '{0, 1, 8, 9, 10, 'h40};
    do_reset();
    data_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("br%0d_pc", i), addr_program, exp_pc[i]);
      if (i < 5) tick();
    end
    chk("br_acc", acc, 16'hFFFF);

    // PC wrap
    clear_mem();
    rom[0] = ins(OP_JMP, 11'h7FF);
    do_reset();
    data_ready = 1'b1;
    #1; chk("wrap_pc0", addr_program, 0); tick();
    #1; chk("wrap_pc1", addr_program, 11'h7FF); tick();
    #1; chk("wrap_pc2", addr_program, 0);

    // Reset asserted mid-wait
    clear_mem();
    ram[16'h10] = 16'h1234;
    rom[0] = ins(OP_LDI, 11'h055);
    rom[1] = ins(OP_LD, 11'h010);
    do_reset();
    data_ready = 1'b0;
    #1; tick();
    #1; chk("rw_rd", rd, 1); chk("rw_acc", acc, 16'h0055); tick();
    #1; chk("rw_wait_rd", rd, 1); chk("rw_wait_pc", addr_program, 1);
    #2; reset = 1'b0;
    #1;
    chk("rw_rst_acc", acc, 0);
    chk("rw_rst_pc", addr_program, 0);
    chk("rw_rst_rd", rd, 0);
    chk("rw_rst_addr", addr_data, 0);
    @(negedge clk);
    reset = 1'b1;
    data_ready = 1'b1;
    #1; chk("rw_restart_pc", addr_program, 0); tick();
    #1; chk("rw_restart_acc", acc, 16'h0055); chk("rw_restart_pc1", addr_program, 1);

    // Single-instruction vector table: LD seeds ACC, then the instruction
    for (int i = 0; i < $size(vt); i++) begin
      clear_mem();
      rom[0] = ins(OP_LD, 11'h7F0);
      rom[1] = ins(vt[i].op, vt[i].opnd);
      ram[11'h7F0] = vt[i].acc0;
      ram[vt[i].opnd] = vt[i].mem;
      do_reset();
      data_ready = 1'b1;
      #1; tick();
      #1; tick();
      #1;
      chk($sformatf("vec%0d_acc", i), acc, vt[i].exp_acc);
      chk($sformatf("vec%0d_pc", i), addr_program, vt[i].exp_pc);
    end

    for (int r = 0; r < 6; r++) rand_run(250, r);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
